// File: rtl/game_pkg.sv
// Shared game constants: PS/2 set-2 scan codes and the held-key index used
// by the host movement path.
package game_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;

  typedef enum logic [2:0] {
    TOM_L,
    TOM_R,
    TOM_J,
    JER_L,
    JER_R,
    JER_J
  } key_e;

endpackage

// File: rtl/host_key_decoder.sv
// Decodes the PS/2 set-2 byte stream into held-key levels for Tom (arrows)
// and Jerry (A/D/W); a stalled prefix sequence is dropped after a timeout.
module host_key_decoder
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       tom_left,
  output logic       tom_right,
  output logic       tom_jump,
  output logic       jerry_left,
  output logic       jerry_right,
  output logic       jerry_jump,
  output logic       seq_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    keys_q, keys_d;
  logic          seq_err_q, seq_err_d;

  logic  fin, ext, brk, hit;
  key_e  key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      keys_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      seq_err_q <= seq_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    keys_d    = keys_q;
    seq_err_d = 1'b0;
    fin       = 1'b0;
    ext       = 1'b0;
    brk       = 1'b0;
    hit       = 1'b0;
    key       = TOM_L;

    if (rx_valid) begin
      // A byte always beats a same-cycle timeout, so it is handled first.
      unique case (state_q)
        IDLE: begin
          if (rx_data == SC_EXT)      state_d = EXT;
          else if (rx_data == SC_BRK) state_d = BRK;
          else                        fin = 1'b1;
        end
        EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = EXTBRK;
          end else if (rx_data != SC_EXT) begin
            fin     = 1'b1;
            ext     = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          fin     = 1'b1;
          brk     = 1'b1;
          state_d = IDLE;
        end
        EXTBRK: begin
          fin     = 1'b1;
          ext     = 1'b1;
          brk     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (fin) begin
        if (ext) begin
          unique case (rx_data)
            SC_LEFT:  begin hit = 1'b1; key = TOM_L; end
            SC_RIGHT: begin hit = 1'b1; key = TOM_R; end
            SC_UP:    begin hit = 1'b1; key = TOM_J; end
            default:  hit = 1'b0;
          endcase
        end else begin
          unique case (rx_data)
            SC_A:    begin hit = 1'b1; key = JER_L; end
            SC_D:    begin hit = 1'b1; key = JER_R; end
            SC_W:    begin hit = 1'b1; key = JER_J; end
            default: hit = 1'b0;
          endcase
        end
        if (hit) keys_d[key] = ~brk;
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = IDLE;
        seq_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign tom_left    = keys_q[TOM_L];
  assign tom_right   = keys_q[TOM_R];
  assign tom_jump    = keys_q[TOM_J];
  assign jerry_left  = keys_q[JER_L];
  assign jerry_right = keys_q[JER_R];
  assign jerry_jump  = keys_q[JER_J];
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_host_key_decoder.sv
// Bench for host_key_decoder: directed scenarios plus random byte streams,
// checked every cycle against a sequence-buffer reference model.
module tb_host_key_decoder;

  localparam int unsigned T = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tom_left, tom_right, tom_jump;
  logic       jerry_left, jerry_right, jerry_jump, seq_err;

  host_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tom_left   (tom_left),
    .tom_right  (tom_right),
    .tom_jump   (tom_jump),
    .jerry_left (jerry_left),
    .jerry_right(jerry_right),
    .jerry_jump (jerry_jump),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference: bytes of the pending prefix, held keys, expected error pulse.
  logic [7:0] seq[$];
  logic [5:0] m_keys = '0;
  logic       m_err  = 1'b0;
  int         cyc    = 0;
  int         last_byte = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int key_of(input bit is_ext, input logic [7:0] code);
    if (is_ext) begin
      case (code)
        8'h6B:   return 0;
        8'h74:   return 1;
        8'h75:   return 2;
        default: return -1;
      endcase
    end else begin
      case (code)
        8'h1C:   return 3;
        8'h23:   return 4;
        8'h1D:   return 5;
        default: return -1;
      endcase
    end
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [7:0] d);
    bit is_ext, is_brk;
    int k;
    m_err = 1'b0;
    if (r) begin
      seq.delete();
      m_keys = '0;
    end else if (v) begin
      last_byte = cyc;
      if (seq.size() == 0 && (d == 8'hE0 || d == 8'hF0)) begin
        seq.push_back(d);
      end else if (seq.size() == 1 && seq[0] == 8'hE0 && d == 8'hE0) begin
        // duplicated extended prefix: keep waiting
      end else if (seq.size() == 1 && seq[0] == 8'hE0 && d == 8'hF0) begin
        seq.push_back(d);
      end else begin
        is_ext = (seq.size() > 0) && (seq[0] == 8'hE0);
        is_brk = (seq.size() > 0) && (seq[seq.size()-1] == 8'hF0);
        k = key_of(is_ext, d);
        if (k >= 0) m_keys[k] = ~is_brk;
        seq.delete();
      end
    end else if (seq.size() > 0 && (cyc - last_byte) == int'(T)) begin
      seq.delete();
      m_err = 1'b1;
    end
    cyc++;
  endtask

  task automatic cycle(input string tag, input bit r, input bit v, input logic [7:0] d);
    rst      = r;
    rx_valid = v;
    rx_data  = v ? d : 8'h00;
    model_step(r, v, d);
    @(posedge clk);
    #1;
    check_eq(tag, {25'd0, seq_err, jerry_jump, jerry_right, jerry_left,
                   tom_jump, tom_right, tom_left}, {25'd0, m_err, m_keys});
  endtask

  task automatic send(input string tag, input logic [7:0] d, input int gap);
    cycle(tag, 1'b0, 1'b1, d);
    for (int i = 0; i < gap; i++) cycle(tag, 1'b0, 1'b0, 8'h00);
  endtask

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h1C,
                            8'h23, 8'h1D, 8'hE1, 8'hAA, 8'hFA, 8'hE0};

  initial begin
    for (int i = 0; i < 3; i++) cycle("reset", 1'b1, 1'b0, 8'h00);

    send("t1_make", 8'hE0, 9);  send("t1_make", 8'h6B, 3);
    send("t1_brk", 8'hE0, 2);   send("t1_brk", 8'hF0, 2);  send("t1_brk", 8'h6B, 3);

    send("t2_make", 8'h1D, 3);
    send("t2_brk", 8'hF0, 1);   send("t2_brk", 8'h1D, 3);

    send("t3_plain6b", 8'h6B, 2);
    send("t3_ext1c", 8'hE0, 1); send("t3_ext1c", 8'h1C, 2);

    send("t4_timeout", 8'hE0, T + 4);
    send("t4_after", 8'h74, 3);

    send("t5_hold", 8'h1C, 1);
    send("t5_hold", 8'hE0, 1);  send("t5_hold", 8'h74, 1);
    send("t5_mid", 8'hE0, 1);   send("t5_mid", 8'hF0, 1);
    cycle("t5_rst", 1'b1, 1'b0, 8'h00);
    send("t5_again", 8'h1C, 2);

    send("t6_rpt", 8'h1C, 1);
    for (int i = 0; i < 5; i++) send("t6_rpt", 8'h1C, 2);
    send("t6_brk", 8'hF0, 1);   send("t6_brk", 8'h1C, 2);

    // EXT then E0 then timeout boundary: a byte arriving exactly at the limit wins
    send("edge_dup", 8'hE0, 2); send("edge_dup", 8'hE0, T - 1);
    send("edge_win", 8'h75, 2);

    for (int n = 0; n < 3000; n++) begin
      int unsigned r = $urandom_range(0, 199);
      if (r == 0) begin
        cycle("rand_rst", 1'b1, 1'b0, 8'h00);
      end else if (r < 4) begin
        for (int i = 0; i < int'(T) + 2; i++) cycle("rand_gap", 1'b0, 1'b0, 8'h00);
      end else if (r < 80) begin
        logic [7:0] b;
        b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
        cycle("rand_byte", 1'b0, 1'b1, b);
      end else begin
        cycle("rand_idle", 1'b0, 1'b0, 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
